// File: rtl/iq_pkg.sv
// Shared issue-queue constants and types (allocator, CIQ, arbiter, wakeup).
package iq_pkg;

  localparam int unsigned INSTR_NUM = 4;
  localparam int unsigned ISSUE_NUM = 4;
  localparam int unsigned CIQ_DEPTH = 16;
  localparam int unsigned IQ_ADDR_W = 4;
  localparam int unsigned AGE       = 5;

  localparam int unsigned CNT_W  = IQ_ADDR_W + 1;
  localparam int unsigned LANE_W = $clog2(INSTR_NUM);
  localparam int unsigned SLOT_W = $clog2(INSTR_NUM + 1);

  typedef logic [IQ_ADDR_W-1:0] iq_addr_t;
  typedef logic [AGE-1:0]       iq_age_t;
  typedef logic [CNT_W-1:0]     iq_cnt_t;

  // Per-lane CIQ write payload
  typedef struct packed {
    iq_addr_t addr;
    iq_age_t  age;
  } iq_wr_t;

  function automatic iq_cnt_t count_ones(input logic [CIQ_DEPTH-1:0] v);
    iq_cnt_t n;
    n = '0;
    for (int unsigned k = 0; k < CIQ_DEPTH; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/iq_free_pick.sv
// Returns the indices of the lowest INSTR_NUM free CIQ entries, lowest first.
module iq_free_pick
  import iq_pkg::*;
(
  input  logic [CIQ_DEPTH-1:0]           free_vec,
  output logic [INSTR_NUM*IQ_ADDR_W-1:0] pick_addr,
  output logic [INSTR_NUM-1:0]           pick_vld
);

  logic [SLOT_W-1:0] found;

  always_comb begin
    pick_addr = '0;
    pick_vld  = '0;
    found     = '0;
    for (int unsigned e = 0; e < CIQ_DEPTH; e++) begin
      if (free_vec[e] && (found < SLOT_W'(INSTR_NUM))) begin
        for (int unsigned s = 0; s < INSTR_NUM; s++) begin
          if (found == SLOT_W'(s)) begin
            pick_addr[s*IQ_ADDR_W +: IQ_ADDR_W] = IQ_ADDR_W'(e);
            pick_vld[s]                         = 1'b1;
          end
        end
        found = found + SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iq_alloc.sv
// Issue-queue entry allocator: hands out free CIQ entries and age tags per dispatch group.
// Optional stall counter output enabled by IQ_ALLOC_STALL_CNT_EN.
module iq_alloc
  import iq_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [INSTR_NUM-1:0]           dispatch_valid,
  output logic                           dispatch_ready,
  output logic [INSTR_NUM*IQ_ADDR_W-1:0] free_addr,
  output logic [INSTR_NUM-1:0]           free_valid,
  output logic [INSTR_NUM*AGE-1:0]       age,
  input  logic [ISSUE_NUM*IQ_ADDR_W-1:0] arbit_addr,
  input  logic [ISSUE_NUM-1:0]           arbit_grant,
  input  logic                           flush,
  output logic [CNT_W-1:0]               free_cnt,
  output logic                           iq_full,
  output logic                           iq_empty
`ifdef IQ_ALLOC_STALL_CNT_EN
  ,
  output logic [31:0]                    stall_cnt
`endif
);

  logic [CIQ_DEPTH-1:0]           free_vec;
  logic [CIQ_DEPTH-1:0]           free_vec_nxt;
  logic [CIQ_DEPTH-1:0]           alloc_mask;
  logic [CIQ_DEPTH-1:0]           grant_mask;
  logic [CIQ_DEPTH-1:0]           rel_mask;
  iq_age_t                        age_cnt;
  iq_cnt_t                        need;
  iq_cnt_t                        free_cnt_nxt;
  logic                           fire;
  logic                           dup_grant;
  logic                           bad_grant;
  logic [LANE_W-1:0]              rank [INSTR_NUM];
  logic [INSTR_NUM*IQ_ADDR_W-1:0] pick_addr;
  logic [INSTR_NUM-1:0]           pick_vld;
  iq_addr_t                       pick_arr [INSTR_NUM];
  iq_wr_t                         lane_wr [INSTR_NUM];

  iq_free_pick u_free_pick (
    .free_vec  (free_vec),
    .pick_addr (pick_addr),
    .pick_vld  (pick_vld)
  );

  for (genvar s = 0; s < INSTR_NUM; s++) begin : g_pick
    assign pick_arr[s] = pick_addr[s*IQ_ADDR_W +: IQ_ADDR_W];
  end

  // Rank of each lane among valid lanes, and group size
  always_comb begin
    logic [SLOT_W-1:0] run;
    run = '0;
    for (int unsigned i = 0; i < INSTR_NUM; i++) begin
      rank[i] = LANE_W'(run);
      run     = run + SLOT_W'(dispatch_valid[i]);
    end
    need = CNT_W'(run);
  end

  assign dispatch_ready = rst_n & ~flush & (free_cnt >= need);
  assign fire           = dispatch_ready & (need != '0);
  assign free_valid     = dispatch_valid & {INSTR_NUM{dispatch_ready}};

  // Lane address/age assignment and the allocation mask
  always_comb begin
    alloc_mask = '0;
    free_addr  = '0;
    age        = '0;
    for (int unsigned i = 0; i < INSTR_NUM; i++) begin
      lane_wr[i] = '0;
      if (dispatch_valid[i]) begin
        lane_wr[i].addr = pick_arr[rank[i]];
        lane_wr[i].age  = age_cnt + AGE'(rank[i]);
      end
      if (free_valid[i]) begin
        alloc_mask[lane_wr[i].addr] = 1'b1;
      end
      free_addr[i*IQ_ADDR_W +: IQ_ADDR_W] = lane_wr[i].addr;
      age[i*AGE +: AGE]                   = lane_wr[i].age;
    end
  end

  // Releases: duplicates collapse in the mask, grants to free entries drop out
  always_comb begin
    grant_mask = '0;
    dup_grant  = 1'b0;
    for (int unsigned j = 0; j < ISSUE_NUM; j++) begin
      if (arbit_grant[j]) begin
        grant_mask[arbit_addr[j*IQ_ADDR_W +: IQ_ADDR_W]] = 1'b1;
        for (int unsigned k = 0; k < j; k++) begin
          if (arbit_grant[k] &&
              (arbit_addr[k*IQ_ADDR_W +: IQ_ADDR_W] == arbit_addr[j*IQ_ADDR_W +: IQ_ADDR_W])) begin
            dup_grant = 1'b1;
          end
        end
      end
    end
  end

  assign rel_mask     = grant_mask & ~free_vec;
  assign bad_grant    = |(grant_mask & free_vec);
  assign free_vec_nxt = (free_vec & ~alloc_mask) | rel_mask;
  assign free_cnt_nxt = free_cnt + count_ones(rel_mask) - count_ones(alloc_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_vec <= '1;
      free_cnt <= CNT_W'(CIQ_DEPTH);
      age_cnt  <= '0;
    end else if (flush) begin
      free_vec <= '1;
      free_cnt <= CNT_W'(CIQ_DEPTH);
      age_cnt  <= '0;
    end else begin
      free_vec <= free_vec_nxt;
      free_cnt <= free_cnt_nxt;
      if (fire) begin
        age_cnt <= age_cnt + AGE'(need);
      end
    end
  end

  assign iq_full  = (free_cnt == '0);
  assign iq_empty = (free_cnt == CNT_W'(CIQ_DEPTH));

`ifdef IQ_ALLOC_STALL_CNT_EN
  // Cycles where rename had work but the group did not fit; saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((need != '0) && !dispatch_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  a_dup_grant: assert property (@(posedge clk) disable iff (!rst_n || flush) !dup_grant)
    else $error("iq_alloc: two grant lanes release the same entry");
  a_bad_grant: assert property (@(posedge clk) disable iff (!rst_n || flush) !bad_grant)
    else $error("iq_alloc: grant releases an entry that is already free");
  a_pick_ok: assert property (@(posedge clk) disable iff (!rst_n)
                              !fire || (count_ones(CIQ_DEPTH'(pick_vld)) >= need))
    else $error("iq_alloc: accepted group larger than available picks");

endmodule

// File: tb/tb_iq_alloc.sv
// Randomized and directed checks of iq_alloc against a free-list reference model.
module tb_iq_alloc;
  import iq_pkg::*;

  localparam int AGE_MOD = 1 << AGE;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [INSTR_NUM-1:0]           dispatch_valid;
  logic                           dispatch_ready;
  logic [INSTR_NUM*IQ_ADDR_W-1:0] free_addr;
  logic [INSTR_NUM-1:0]           free_valid;
  logic [INSTR_NUM*AGE-1:0]       age;
  logic [ISSUE_NUM*IQ_ADDR_W-1:0] arbit_addr;
  logic [ISSUE_NUM-1:0]           arbit_grant;
  logic                           flush;
  logic [CNT_W-1:0]               free_cnt;
  logic                           iq_full;
  logic                           iq_empty;
`ifdef IQ_ALLOC_STALL_CNT_EN
  logic [31:0]                    stall_cnt;
`endif

  iq_alloc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .free_addr      (free_addr),
    .free_valid     (free_valid),
    .age            (age),
    .arbit_addr     (arbit_addr),
    .arbit_grant    (arbit_grant),
    .flush          (flush),
    .free_cnt       (free_cnt),
    .iq_full        (iq_full),
    .iq_empty       (iq_empty)
`ifdef IQ_ALLOC_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: set of free entries and next age tag
  bit                   m_free [CIQ_DEPTH];
  int                   m_age;
  bit                   e_ready;
  bit [INSTR_NUM-1:0]   e_fv;
  int                   e_addr [INSTR_NUM];
  int                   e_age  [INSTR_NUM];
  int                   ga     [ISSUE_NUM];

  function automatic int m_cnt();
    int n = 0;
    for (int e = 0; e < CIQ_DEPTH; e++) n += int'(m_free[e]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int e = 0; e < CIQ_DEPTH; e++) m_free[e] = 1'b1;
    m_age = 0;
  endfunction

  function automatic void model_eval(input logic [INSTR_NUM-1:0] dv, input bit fl);
    int q[$];
    int need = 0;
    int rank = 0;
    for (int e = 0; e < CIQ_DEPTH; e++) if (m_free[e]) q.push_back(e);
    for (int i = 0; i < INSTR_NUM; i++) need += int'(dv[i]);
    e_ready = !fl && (need <= q.size());
    for (int i = 0; i < INSTR_NUM; i++) begin
      e_fv[i] = 1'b0; e_addr[i] = 0; e_age[i] = 0;
      if (dv[i] && e_ready) begin
        e_fv[i]   = 1'b1;
        e_addr[i] = q[rank];
        e_age[i]  = (m_age + rank) % AGE_MOD;
      end
      if (dv[i]) rank++;
    end
  endfunction

  function automatic logic [IQ_ADDR_W-1:0] lane_addr(input int i);
    return free_addr[i*IQ_ADDR_W +: IQ_ADDR_W];
  endfunction

  function automatic logic [AGE-1:0] lane_age(input int i);
    return age[i*AGE +: AGE];
  endfunction

  task automatic apply(input logic [INSTR_NUM-1:0] dv, input logic [ISSUE_NUM-1:0] gr, input bit fl);
    dispatch_valid = dv;
    arbit_grant    = gr;
    flush          = fl;
    for (int j = 0; j < ISSUE_NUM; j++) arbit_addr[j*IQ_ADDR_W +: IQ_ADDR_W] = IQ_ADDR_W'(ga[j]);
    model_eval(dv, fl);
  endtask

  // Commit the model for the applied inputs, then move past the next rising edge
  task automatic advance();
    bit snap [CIQ_DEPTH];
    int need = 0;
    snap = m_free;
    if (flush) begin
      model_reset();
    end else begin
      for (int i = 0; i < INSTR_NUM; i++) begin
        if (e_fv[i]) begin
          m_free[e_addr[i]] = 1'b0;
          need++;
        end
      end
      m_age = (m_age + need) % AGE_MOD;
      for (int j = 0; j < ISSUE_NUM; j++)
        if (arbit_grant[j] && !snap[ga[j]]) m_free[ga[j]] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pick_grants(input int max_rel, output logic [ISSUE_NUM-1:0] gr);
    int q[$];
    int idx;
    gr = '0;
    for (int e = 0; e < CIQ_DEPTH; e++) if (!m_free[e]) q.push_back(e);
    for (int j = 0; j < ISSUE_NUM; j++) begin
      ga[j] = int'($urandom_range(CIQ_DEPTH - 1));
      if (j < max_rel && q.size() > 0) begin
        idx   = int'($urandom_range(q.size() - 1));
        ga[j] = q[idx];
        q.delete(idx);
        gr[j] = 1'b1;
      end
    end
  endtask

  task automatic release_some();
    logic [ISSUE_NUM-1:0] gr;
    pick_grants(ISSUE_NUM, gr);
    apply('0, gr, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int j = 0; j < ISSUE_NUM; j++) ga[j] = 0;
    apply('0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    dispatch_valid = '1;
    #1;
    n_vec++; if (dispatch_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", dispatch_ready); end
    n_vec++; if (free_valid !== '0) begin n_err++; $display("FAIL reset_fv: got %b want 0000", free_valid); end
    n_vec++; if (free_cnt !== CNT_W'(16)) begin n_err++; $display("FAIL reset_cnt: got %0d want 16", free_cnt); end
    n_vec++; if (iq_empty !== 1'b1 || iq_full !== 1'b0) begin n_err++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", iq_empty, iq_full); end
    dispatch_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_group();
    apply(4'b1111, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (dispatch_ready !== 1'b1) begin n_err++; $display("FAIL first_ready: got %b want 1", dispatch_ready); end
    n_vec++; if (free_valid !== 4'b1111) begin n_err++; $display("FAIL first_fv: got %b want 1111", free_valid); end
    for (int i = 0; i < INSTR_NUM; i++) begin
      n_vec++; if (lane_addr(i) !== IQ_ADDR_W'(i)) begin n_err++; $display("FAIL first_addr lane%0d: got %0d want %0d", i, lane_addr(i), i); end
      n_vec++; if (lane_age(i) !== AGE'(i)) begin n_err++; $display("FAIL first_age lane%0d: got %0d want %0d", i, lane_age(i), i); end
    end
    advance();
    n_vec++; if (free_cnt !== CNT_W'(12)) begin n_err++; $display("FAIL first_cnt: got %0d want 12", free_cnt); end
  endtask

  task automatic test_fill_stall();
    for (int g = 1; g < 4; g++) begin
      apply(4'b1111, '0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < INSTR_NUM; i++) begin
        n_vec++; if (lane_addr(i) !== IQ_ADDR_W'(4*g + i)) begin n_err++; $display("FAIL fill_addr g%0d lane%0d: got %0d want %0d", g, i, lane_addr(i), 4*g + i); end
      end
      advance();
    end
    n_vec++; if (iq_full !== 1'b1 || free_cnt !== '0) begin n_err++; $display("FAIL fill_full: got full=%b cnt=%0d want 1/0", iq_full, free_cnt); end
    for (int c = 0; c < 10; c++) begin
      apply(4'b0001, '0, 1'b0);
      @(negedge clk);
      n_vec++; if (dispatch_ready !== 1'b0 || free_valid !== '0) begin n_err++; $display("FAIL stall_ready c%0d: got ready=%b fv=%b want 0/0000", c, dispatch_ready, free_valid); end
      n_vec++; if (free_cnt !== '0) begin n_err++; $display("FAIL stall_cnt c%0d: got %0d want 0", c, free_cnt); end
      advance();
    end
  endtask

  task automatic test_release_full();
    ga[0] = 5; ga[1] = 9; ga[2] = 0; ga[3] = 0;
    apply(4'b0101, 4'b0011, 1'b0);
    @(negedge clk);
    n_vec++; if (dispatch_ready !== 1'b0) begin n_err++; $display("FAIL relfull_same_cycle: got ready=%b want 0", dispatch_ready); end
    advance();
    apply(4'b0101, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (dispatch_ready !== 1'b1 || free_valid !== 4'b0101) begin n_err++; $display("FAIL relfull_accept: got ready=%b fv=%b want 1/0101", dispatch_ready, free_valid); end
    n_vec++; if (lane_addr(0) !== 4'd5 || lane_addr(2) !== 4'd9) begin n_err++; $display("FAIL relfull_addr: got lane0=%0d lane2=%0d want 5/9", lane_addr(0), lane_addr(2)); end
    n_vec++; if (lane_age(0) !== 5'd16 || lane_age(2) !== 5'd17) begin n_err++; $display("FAIL relfull_age: got lane0=%0d lane2=%0d want 16/17", lane_age(0), lane_age(2)); end
    advance();
    n_vec++; if (free_cnt !== '0) begin n_err++; $display("FAIL relfull_cnt: got %0d want 0", free_cnt); end
  endtask

  task automatic test_sparse();
    for (int j = 0; j < ISSUE_NUM; j++) ga[j] = 4 + j;
    apply('0, 4'b1111, 1'b0);
    advance();
    for (int j = 0; j < ISSUE_NUM; j++) ga[j] = 12 + j;
    apply('0, 4'b1111, 1'b0);
    advance();
    n_vec++; if (free_cnt !== CNT_W'(8)) begin n_err++; $display("FAIL sparse_cnt: got %0d want 8", free_cnt); end
    apply(4'b1010, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (free_valid !== 4'b1010) begin n_err++; $display("FAIL sparse_fv: got %b want 1010", free_valid); end
    n_vec++; if (lane_addr(1) !== 4'd4 || lane_addr(3) !== 4'd5) begin n_err++; $display("FAIL sparse_addr: got lane1=%0d lane3=%0d want 4/5", lane_addr(1), lane_addr(3)); end
    n_vec++; if (lane_age(1) !== 5'd18 || lane_age(3) !== 5'd19) begin n_err++; $display("FAIL sparse_age: got lane1=%0d lane3=%0d want 18/19", lane_age(1), lane_age(3)); end
    n_vec++; if (lane_addr(0) !== '0 || lane_age(2) !== '0) begin n_err++; $display("FAIL sparse_idle_lanes: got addr0=%0d age2=%0d want 0/0", lane_addr(0), lane_age(2)); end
    advance();
    apply(4'b0001, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (lane_age(0) !== 5'd20 || lane_addr(0) !== 4'd6) begin n_err++; $display("FAIL sparse_next: got age=%0d addr=%0d want 20/6", lane_age(0), lane_addr(0)); end
    advance();
  endtask

  task automatic test_age_wrap();
    int n;
    int iter = 0;
    while (m_age != 30 && iter < 200) begin
      n = (30 - m_age + AGE_MOD) % AGE_MOD;
      if (n > INSTR_NUM) n = INSTR_NUM;
      if (m_cnt() >= n) begin
        apply(INSTR_NUM'((1 << n) - 1), '0, 1'b0);
        @(negedge clk);
        n_vec++; if (dispatch_ready !== 1'b1) begin n_err++; $display("FAIL wrap_step_ready: got %b want 1", dispatch_ready); end
        advance();
      end else begin
        release_some();
      end
      iter++;
    end
    n_vec++; if (iter >= 200) begin n_err++; $display("FAIL wrap_reach: got age %0d want 30 within budget", m_age); end
    while (m_cnt() < 4) release_some();
    apply(4'b1111, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (lane_age(0) !== 5'd30 || lane_age(1) !== 5'd31 || lane_age(2) !== 5'd0 || lane_age(3) !== 5'd1) begin
      n_err++; $display("FAIL wrap_ages: got {%0d,%0d,%0d,%0d} want {1,0,31,30}", lane_age(3), lane_age(2), lane_age(1), lane_age(0));
    end
    for (int i = 0; i < INSTR_NUM; i++) begin
      n_vec++; if (lane_addr(i) !== IQ_ADDR_W'(e_addr[i])) begin n_err++; $display("FAIL wrap_addr lane%0d: got %0d want %0d", i, lane_addr(i), e_addr[i]); end
    end
    advance();
    while (m_cnt() < 1) release_some();
    apply(4'b0001, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (lane_age(0) !== 5'd2) begin n_err++; $display("FAIL wrap_after: got %0d want 2", lane_age(0)); end
    advance();
  endtask

  task automatic test_random();
    logic [ISSUE_NUM-1:0] gr;
    logic [INSTR_NUM-1:0] dv;
    bit                   fl;
    for (int c = 0; c < 400; c++) begin
      dv = INSTR_NUM'($urandom);
      fl = ($urandom_range(31) == 0);
      pick_grants(int'($urandom_range(ISSUE_NUM)), gr);
      apply(dv, gr, fl);
      @(negedge clk);
      n_vec++; if (dispatch_ready !== e_ready || free_valid !== e_fv) begin
        n_err++; $display("FAIL rand_ready c%0d: got ready=%b fv=%b want %b/%b", c, dispatch_ready, free_valid, e_ready, e_fv);
      end
      for (int i = 0; i < INSTR_NUM; i++) begin
        if (e_fv[i]) begin
          n_vec++; if (lane_addr(i) !== IQ_ADDR_W'(e_addr[i]) || lane_age(i) !== AGE'(e_age[i])) begin
            n_err++; $display("FAIL rand_lane c%0d lane%0d: got addr=%0d age=%0d want %0d/%0d", c, i, lane_addr(i), lane_age(i), e_addr[i], e_age[i]);
          end
        end
      end
      n_vec++; if (free_cnt !== CNT_W'(m_cnt()) || iq_full !== (m_cnt() == 0) || iq_empty !== (m_cnt() == CIQ_DEPTH)) begin
        n_err++; $display("FAIL rand_cnt c%0d: got cnt=%0d full=%b empty=%b want cnt=%0d", c, free_cnt, iq_full, iq_empty, m_cnt());
      end
      advance();
    end
  endtask

  task automatic test_flush();
    apply('0, '0, 1'b1);
    advance();
    apply(4'b0111, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (lane_addr(0) !== 4'd0 || lane_addr(1) !== 4'd1 || lane_addr(2) !== 4'd2) begin
      n_err++; $display("FAIL flush_prealloc: got %0d,%0d,%0d want 0,1,2", lane_addr(0), lane_addr(1), lane_addr(2));
    end
    advance();
    ga[0] = 1;
    apply(4'b1111, 4'b0001, 1'b1);
    @(negedge clk);
    n_vec++; if (dispatch_ready !== 1'b0 || free_valid !== '0) begin n_err++; $display("FAIL flush_block: got ready=%b fv=%b want 0/0000", dispatch_ready, free_valid); end
    advance();
    n_vec++; if (free_cnt !== CNT_W'(16) || iq_empty !== 1'b1 || iq_full !== 1'b0) begin
      n_err++; $display("FAIL flush_state: got cnt=%0d empty=%b full=%b want 16/1/0", free_cnt, iq_empty, iq_full);
    end
    apply(4'b0001, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (lane_age(0) !== '0 || lane_addr(0) !== '0) begin n_err++; $display("FAIL flush_age: got age=%0d addr=%0d want 0/0", lane_age(0), lane_addr(0)); end
    advance();
    apply(4'b1111, '0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (free_valid !== '0 || dispatch_ready !== 1'b0) begin n_err++; $display("FAIL async_reset_fv: got fv=%b ready=%b want 0000/0", free_valid, dispatch_ready); end
    n_vec++; if (free_cnt !== CNT_W'(16)) begin n_err++; $display("FAIL async_reset_cnt: got %0d want 16", free_cnt); end
    dispatch_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_group();
    test_fill_stall();
    test_release_full();
    test_sparse();
    test_age_wrap();
    test_random();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iq_alloc.md
Name: iq_alloc

Overview:
Issue-queue entry allocator, directly upstream of the 16-entry centralized issue queue (CIQ).
- Tracks which CIQ entries are free and grants up to INSTR_NUM renamed instructions per cycle a free entry address and an age tag. This drives the CIQ write port (free_addr / free_valid / age).
- Returns entries to the free pool when the arbiter grants them for issue.
- Back-pressures rename when the CIQ cannot hold the whole dispatch group.

Parameters:
- INSTR_NUM, 4: dispatch lanes per cycle.
- ISSUE_NUM, 4: arbiter grant lanes per cycle (release ports).
- CIQ_DEPTH, 16: CIQ entries.
- IQ_ADDR_W, 4: CIQ address width, equal to log2(CIQ_DEPTH).
- AGE, 5: age tag width; must satisfy 2^AGE >= 2*CIQ_DEPTH.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- dispatch_valid, in, INSTR_NUM: per-lane valid renamed instruction from rename.
- dispatch_ready, out, 1: the whole group can be accepted this cycle.
- free_addr, out, INSTR_NUM*IQ_ADDR_W: CIQ entry for each lane; lane i occupies bits [i*IQ_ADDR_W +: IQ_ADDR_W].
- free_valid, out, INSTR_NUM: lane i is being written into the CIQ this cycle.
- age, out, INSTR_NUM*AGE: age tag for each lane.
- arbit_addr, in, ISSUE_NUM*IQ_ADDR_W: CIQ address granted by the arbiter.
- arbit_grant, in, ISSUE_NUM: arbit_addr lane is valid; that entry is released.
- flush, in, 1: pipeline flush; frees all entries.
- free_cnt, out, IQ_ADDR_W+1: number of free entries, 0..CIQ_DEPTH.
- iq_full, out, 1: free_cnt == 0.
- iq_empty, out, 1: free_cnt == CIQ_DEPTH.

Behaviour:
- State registers:
  - free_vec[CIQ_DEPTH-1:0], where 1 = free.
  - free_cnt.
  - age_cnt[AGE-1:0].
- Reset (async on rst_n low) and the values it gives:
  - free_vec = all ones, free_cnt = CIQ_DEPTH, age_cnt = 0.
  - Resulting outputs: iq_empty=1, iq_full=0.
  - While rst_n is low, dispatch_ready=0 and free_valid=0.
- Lane selection:
  - need = popcount(dispatch_valid).
  - dispatch_ready = (free_cnt >= need) & ~flush. Acceptance is all-or-nothing; a partial group is never accepted.
  - fire = dispatch_ready & (need != 0).
  - free_valid[i] = dispatch_valid[i] & dispatch_ready.
- Address and age assignment (combinational from current state; zero-cycle latency to the CIQ write at the next clk edge):
  - rank_i = number of valid lanes below lane i.
  - free_addr lane i = index of the (rank_i)-th set bit of free_vec, counting from the lowest index.
  - age lane i = age_cnt + rank_i, modulo 2^AGE.
  - Invalid lanes drive free_addr=0 and age=0.
- Register update on rising clk, in priority order:
  - If flush: free_vec = all ones, free_cnt = CIQ_DEPTH, age_cnt = 0. Allocations and releases in that cycle are discarded.
  - Otherwise:
    - Clear free_vec bits of entries allocated this cycle.
    - Set free_vec bits for each arbit_grant[j] at arbit_addr[j].
    - free_cnt += released - allocated.
    - age_cnt += need when fire.
- Release timing: a released entry is allocatable from the next cycle, never in the same cycle.
- Duplicate or invalid releases:
  - Two grant lanes naming the same address count as one release.
  - A grant to an entry that is already free is ignored, with no free_cnt change.
  - Both cases are protocol errors and are flagged by assertions in simulation.
- Full/empty boundaries:
  - At free_cnt=0: dispatch_ready=1 only if need=0.
  - A release of N entries while full permits allocation of N entries on the next cycle.
- age_cnt wraps modulo 2^AGE. Because at most CIQ_DEPTH entries are live, the consumer compares ages by half-range (modular) subtraction.

Optional Feature:
- Macro IQ_ALLOC_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[31:0].
  - stall_cnt increments every cycle with need!=0 & ~dispatch_ready & ~flush, and saturates at all ones.
  - Reset value is 0; flush does not clear it.
- When undefined: the port and counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Package iq_pkg:
  - Constants CIQ_DEPTH, IQ_ADDR_W, AGE, INSTR_NUM, ISSUE_NUM.
  - Typedefs iq_addr_t and iq_age_t.
  - This package is shared with the issue queue, arbiter and wakeup.
- Sub-module iq_free_pick: purely combinational. Given free_vec, it returns the indices of the lowest INSTR_NUM set bits plus a per-slot valid.

Test Plan:
1. Reset, then dispatch_valid=4'b1111 -> same cycle dispatch_ready=1, free_addr={3,2,1,0} (lane3..lane0), age={3,2,1,0}; next cycle free_cnt=12.
2. Fill the CIQ with 4 groups of 4 -> iq_full=1. Then dispatch_valid=4'b0001 -> dispatch_ready=0 and free_valid=0; free_cnt stays 0 across 10 stall cycles.
3. While full, arbit_grant=4'b0011 with arbit_addr lanes {5,9} and dispatch_valid=4'b0101 in the same cycle -> not accepted that cycle. Next cycle it is accepted with lane0->5, lane2->9; free_cnt returns to 0.
4. Sparse lanes: dispatch_valid=4'b1010 with free_vec=16'hF0F0 -> lane1 addr=4, lane3 addr=5, free_valid=4'b1010, age_cnt advances by 2.
5. Age wrap: age_cnt=30 with 4 valid lanes -> ages {1,0,31,30} (lane3..lane0); age_cnt becomes 2.
6. Assert flush with 3 entries allocated and a simultaneous grant -> next cycle free_cnt=16, iq_empty=1, age_cnt=0. Then assert rst_n low mid-operation -> free_valid=0 immediately (asynchronously).
